mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single mainMem port between the instruction-fetch requester (I, read-only) and the load/store requester (D).
//  Grants requesters round-robin.
//  Breaks every 1/4/8/16-word burst into single-word accesses (mem_acc_size=00) with its own beat counter.
//  mainMem busy is therefore not used. Sits between the fetch/mem pipeline stages and mainMem.
// PARAMETERS
//  ADDRESS_SIZE  32  address width, both requesters and mem side
//  DATA_SIZE     32  data word width
//  ACCESS_SIZE   2   acc_size width; 00=1, 01=4, 10=8, 11=16 words
// PORTS
//  clk          in   1             clock, all state on posedge
//  reset        in   1             asynchronous, active-high reset
//  i_req        in   1             I request; held high until i_gnt
//  i_addr       in   ADDRESS_SIZE  I burst base byte address
//  i_acc_size   in   ACCESS_SIZE   I burst length code
//  i_gnt        out  1             one-cycle pulse: I request accepted
//  i_rdata      out  DATA_SIZE     = mem_d_out; meaningful only while i_rvalid
//  i_rvalid     out  1             I read word valid
//  i_done       out  1             one-cycle pulse with last I word
//  d_req        in   1             D request; held until d_gnt
//  d_addr       in   ADDRESS_SIZE  D burst base byte address
//  d_acc_size   in   ACCESS_SIZE   D burst length code
//  d_wren       in   1             1=store burst, 0=load burst
//  d_wdata      in   DATA_SIZE     store word; must be valid while d_wready
//  d_gnt        out  1             one-cycle pulse: D request accepted
//  d_wready     out  1             current store word consumed this cycle
//  d_rdata      out  DATA_SIZE     = mem_d_out; meaningful only while d_rvalid
//  d_rvalid     out  1             D load word valid
//  d_done       out  1             one-cycle pulse with last D word/beat
//  mem_addr     out  ADDRESS_SIZE  to mainMem addr
//  mem_d_in     out  DATA_SIZE     to mainMem d_in (= d_wdata during store beats, else 0)
//  mem_d_out    in   DATA_SIZE     from mainMem d_out; valid 1 cycle after read beat
//  mem_acc_size out  ACCESS_SIZE   constant 00
//  mem_wren     out  1             high only on store beats
//  mem_enable   out  1             high on every issued beat
// BEHAVIOUR
//  FSM IDLE -> GRANT -> BEAT -> (read: DRAIN) -> IDLE. Reset: IDLE, all outputs 0, rr pointer = D preferred.
//  IDLE: if any req, pick owner:
//   - only one req: that requester
//   - both reqs: the one not granted last (reset: D)
//   Latch owner, base addr with bits[1:0] forced 00, beats = 1/4/8/16 from acc_size, wren (I: 0). Go GRANT.
//  GRANT (1 cycle): owner gnt=1; beat cnt=0; rr pointer updated; go BEAT. Requester may drop req after gnt.
//  BEAT (beats cycles): mem_enable=1, mem_addr = base + 4*cnt (mod 2^ADDRESS_SIZE, no range check),
//   mem_wren=latched wren; cnt++.
//   Store: d_wready=1 each beat, mem_d_in=d_wdata; d_done with last beat; then IDLE.
//   Load: go DRAIN after last beat.
//  Read data: rvalid for owner in cycle after each read beat (BEAT cycles 2..N and DRAIN); rdata order = address order.
//   done asserted with last rvalid, in DRAIN. DRAIN exits to IDLE.
//  Occupancy: 1-word read = 4 cycles IDLE..DRAIN, 16-word = 19; write N = N+2. Min 1 IDLE cycle between bursts.
//  Requests arriving outside IDLE wait; never preempted; non-owner outputs stay 0.
//  cnt is 4 bits; last beat at cnt = beats-1 (15 for acc_size 11), no overflow.
//  reset mid-burst: immediate IDLE, outputs 0, no further rvalid/done/wready; partial store is not undone.
// TESTING
//  reset, no reqs -> all outputs 0, mem_enable never high for 20 cycles
//  I req addr 0x80020000 size 01, mem pre-loaded 0x11..0x44 -> i_gnt 1 cycle, 4 rvalid words 0x11,0x22,0x33,0x44, i_done on 4th
//  D store addr 0x80020010 size 00 data 0xDEADBEEF -> one beat mem_wren=1 mem_addr 0x80020010; readback returns 0xDEADBEEF
//  i_req and d_req same cycle after reset, held -> D granted first, then I; repeating both -> strict alternation
//  D load size 11 at 0x80020003 -> 16 beats addr 0x80020000..0x8002003C step 4, d_done with 16th rvalid, cnt no wrap
//  reset pulse during 3rd beat of 8-word I read -> next cycle IDLE, no i_rvalid/i_done, new D req granted normally

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-word mainMem port between instruction fetch (I)
// and load/store (D); every burst is issued as a sequence of single-word beats.
module mem_port_arbiter #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [ACCESS_SIZE-1:0]  i_acc_size,
  output logic                    i_gnt,
  output logic [DATA_SIZE-1:0]    i_rdata,
  output logic                    i_rvalid,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [ACCESS_SIZE-1:0]  d_acc_size,
  input  logic                    d_wren,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  output logic                    d_gnt,
  output logic                    d_wready,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    d_rvalid,
  output logic                    d_done,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_enable
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, GRANT, BEAT, DRAIN} state_t;

  state_t                  state;
  logic                    owner_d;
  logic                    prefer_d;
  logic                    wren_q;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last;
  logic [ADDRESS_SIZE-1:0] base;
  logic                    pick_d;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [CNT_W-1:0]        cnt_nxt;

  // Index of the final beat for a burst length code (1/4/8/16 words).
  function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] code);
    case (code)
      2'b00:   last_beat = CNT_W'(0);
      2'b01:   last_beat = CNT_W'(3);
      2'b10:   last_beat = CNT_W'(7);
      default: last_beat = CNT_W'(15);
    endcase
  endfunction

  // Lone requester wins; on a tie the one not granted last wins.
  assign pick_d   = d_req & (~i_req | prefer_d);
  assign req_addr = pick_d ? d_addr : i_addr;
  assign cnt_nxt  = cnt + 1'b1;

  assign i_rdata      = mem_d_out;
  assign d_rdata      = mem_d_out;
  assign mem_acc_size = '0;
  assign mem_d_in     = mem_wren ? d_wdata : '0;
  assign d_wready     = mem_wren;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      prefer_d   <= 1'b1;
      wren_q     <= 1'b0;
      cnt        <= '0;
      last       <= '0;
      base       <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      mem_enable <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
    end else begin
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      mem_enable <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= pick_d;
            base    <= req_addr & ~ADDRESS_SIZE'(3);
            last    <= last_beat(pick_d ? d_acc_size[1:0] : i_acc_size[1:0]);
            wren_q  <= pick_d & d_wren;
            i_gnt   <= ~pick_d;
            d_gnt   <= pick_d;
            state   <= GRANT;
          end
        end
        GRANT: begin
          cnt        <= '0;
          prefer_d   <= ~owner_d;
          mem_enable <= 1'b1;
          mem_addr   <= base;
          mem_wren   <= wren_q;
          d_done     <= wren_q && (last == '0);
          state      <= BEAT;
        end
        BEAT: begin
          // Read data for the beat just issued appears one cycle later.
          i_rvalid <= ~wren_q & ~owner_d;
          d_rvalid <= ~wren_q & owner_d;
          if (cnt == last) begin
            if (wren_q) begin
              state <= IDLE;
            end else begin
              i_done <= ~owner_d;
              d_done <= owner_d;
              state  <= DRAIN;
            end
          end else begin
            cnt        <= cnt_nxt;
            mem_enable <= 1'b1;
            mem_addr   <= base + ADDRESS_SIZE'({cnt_nxt, 2'b00});
            mem_wren   <= wren_q;
            d_done     <= wren_q && (cnt_nxt == last);
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a burst-level reference model predicts grant order,
// beat addresses, store data and read data from a golden memory image.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid, i_done;
  logic [AW-1:0] i_addr;
  logic [SW-1:0] i_acc_size;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wren, d_gnt, d_wready, d_rvalid, d_done;
  logic [AW-1:0] d_addr;
  logic [SW-1:0] d_acc_size;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_in;
  logic [DW-1:0] mem_d_out;
  logic [SW-1:0] mem_acc_size;
  logic          mem_wren, mem_enable;

  mem_port_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .ACCESS_SIZE(SW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_acc_size(i_acc_size), .i_gnt(i_gnt),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_acc_size(d_acc_size), .d_wren(d_wren),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_wready(d_wready), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .mem_acc_size(mem_acc_size), .mem_wren(mem_wren), .mem_enable(mem_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(input int i);
    return DW'(32'h11 * (i + 1));
  endfunction

  // mainMem stand-in: single-word access, read data one cycle after the beat.
  logic [DW-1:0] dev_mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= seed(i);
    end else if (mem_enable) begin
      if (mem_wren) dev_mem[mem_addr[9:2]] <= mem_d_in;
      else          mem_d_out <= dev_mem[mem_addr[9:2]];
    end
  end

  logic [11:0] quiet;
  assign quiet = {i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid, d_done,
                  mem_wren, mem_enable, |mem_addr, |mem_d_in, |mem_acc_size};

  logic [DW-1:0] gold [256];
  logic [DW-1:0] wd [16];
  bit            prefer_d;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbeats(input logic [SW-1:0] code);
    return (code == 2'd0) ? 1 : (code == 2'd1) ? 4 : (code == 2'd2) ? 8 : 16;
  endfunction

  task automatic reseed_gold();
    for (int i = 0; i < 256; i++) gold[i] = seed(i);
    prefer_d = 1'b1;
  endtask

  task automatic reset_dut();
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reseed_gold();
  endtask

  task automatic rand_i();
    i_addr     = 32'h8002_0000 + 32'($urandom_range(0, 239)) * 4 + 32'($urandom_range(0, 3));
    i_acc_size = SW'($urandom_range(0, 3));
  endtask

  task automatic rand_d();
    d_addr     = 32'h8002_0000 + 32'($urandom_range(0, 239)) * 4 + 32'($urandom_range(0, 3));
    d_acc_size = SW'($urandom_range(0, 3));
    d_wren     = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
  endtask

  // Waits for the predicted owner's grant, then follows its whole burst.
  task automatic run_burst(input bit is_d);
    logic [31:0] base, ea;
    int n, k, rv, cyc;
    bit wr, got, fin;
    base = (is_d ? d_addr : i_addr) & 32'hFFFF_FFFC;
    n    = nbeats(is_d ? d_acc_size : i_acc_size);
    wr   = is_d & d_wren;
    got  = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      #1;
      got = i_gnt | d_gnt;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!got) return;
    check("gnt_owner", {30'b0, i_gnt, d_gnt}, is_d ? 32'd1 : 32'd2);
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    prefer_d = !is_d;
    k = 0; rv = 0; fin = 1'b0;
    for (cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (wr && k < n) d_wdata = wd[k];
      #1;
      check("other_quiet", is_d ? 32'({i_gnt, i_rvalid, i_done})
                                : 32'({d_gnt, d_wready, d_rvalid, d_done}), 32'd0);
      if (mem_enable) begin
        ea = base + 32'(4 * k);
        check("beat_in_range", 32'(k < n), 32'd1);
        check("beat_addr", mem_addr, ea);
        check("beat_wren", 32'(mem_wren), 32'(wr));
        check("acc_size", 32'(mem_acc_size), 32'd0);
        if (wr && k < n) begin
          check("wready", 32'(d_wready), 32'd1);
          check("wdata", mem_d_in, wd[k]);
          check("store_done", 32'(d_done), 32'(k == n - 1));
          gold[ea[9:2]] = wd[k];
        end
        k++;
      end else begin
        check("wready_idle", 32'(d_wready), 32'd0);
      end
      if (is_d ? d_rvalid : i_rvalid) begin
        ea = base + 32'(4 * rv);
        check("rvalid_on_read", 32'(wr), 32'd0);
        check("rdata", is_d ? d_rdata : i_rdata, gold[ea[9:2]]);
        check("read_done", 32'(is_d ? d_done : i_done), 32'(rv == n - 1));
        rv++;
      end
      if (is_d ? d_done : i_done) begin
        fin = 1'b1;
        check("done_cycle", 32'(cyc), wr ? 32'(n - 1) : 32'(n));
      end
    end
    check("done_seen", 32'(fin), 32'd1);
    check("beats", 32'(k), 32'(n));
    check("rvalid_cnt", 32'(rv), wr ? 32'd0 : 32'(n));
  endtask

  initial begin
    int nb;
    bit got, first;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0; i_acc_size = '0;
    d_req = 1'b0; d_addr = '0; d_acc_size = '0; d_wren = 1'b0; d_wdata = '0;
    reseed_gold();
    repeat (3) @(negedge clk);
    check("reset_quiet", 32'(quiet), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_quiet", 32'(quiet), 32'd0);
    end

    // 4-word fetch of preloaded words 0x11..0x44
    i_addr = 32'h8002_0000; i_acc_size = 2'b01; i_req = 1'b1;
    run_burst(1'b0);

    // single store then readback
    d_addr = 32'h8002_0010; d_acc_size = 2'b00; d_wren = 1'b1; wd[0] = 32'hDEAD_BEEF;
    d_req = 1'b1;
    run_burst(1'b1);
    d_wren = 1'b0; d_req = 1'b1;
    run_burst(1'b1);

    // address wraps modulo 2^32
    d_addr = 32'hFFFF_FFF8; d_acc_size = 2'b01; d_wren = 1'b1;
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
    d_req = 1'b1;
    run_burst(1'b1);
    d_wren = 1'b0; d_req = 1'b1;
    run_burst(1'b1);

    // simultaneous requests after reset alternate starting with D
    reset_dut();
    for (int r = 0; r < 3; r++) begin
      rand_i(); rand_d();
      i_req = 1'b1; d_req = 1'b1;
      first = prefer_d;
      run_burst(first);
      run_burst(!first);
    end

    // 16-word load from unaligned base
    d_addr = 32'h8002_0003; d_acc_size = 2'b11; d_wren = 1'b0; d_req = 1'b1;
    run_burst(1'b1);

    // reset in the 3rd beat of an 8-word fetch
    i_addr = 32'h8002_0040; i_acc_size = 2'b10; i_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #1;
      got = i_gnt;
    end
    check("rst_gnt", 32'(got), 32'd1);
    i_req = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      @(negedge clk);
      #1;
      if (mem_enable) nb++;
    end
    check("rst_beat3", 32'(nb), 32'd3);
    reset = 1'b1;
    #1;
    check("rst_async_clear", 32'(quiet), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    reseed_gold();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("rst_after_quiet", 32'(quiet), 32'd0);
    end
    rand_d();
    d_req = 1'b1;
    run_burst(1'b1);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      rand_i(); rand_d();
      if (mode == 0) begin
        i_req = 1'b1;
        run_burst(1'b0);
      end else if (mode == 1) begin
        d_req = 1'b1;
        run_burst(1'b1);
      end else begin
        i_req = 1'b1; d_req = 1'b1;
        first = prefer_d;
        run_burst(first);
        run_burst(!first);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
